// File: rtl/highlight_blend_if.sv
// rtl/highlight_blend_if.sv - FIFO-side handshake bundle for highlight_blend
interface highlight_blend_if #(
    parameter int PIX_W = 24
);
    logic             in_empty_ped;
    logic [PIX_W-1:0] in_dout_ped;
    logic             in_rd_en_ped;
    logic             in_empty_mask;
    logic [PIX_W-1:0] in_dout_mask;
    logic             in_rd_en_mask;
    logic             out_full;
    logic             out_wr_en;
    logic [PIX_W-1:0] out_din;

    modport master (
        input  in_empty_ped, in_dout_ped,
        output in_rd_en_ped,
        input  in_empty_mask, in_dout_mask,
        output in_rd_en_mask,
        input  out_full,
        output out_wr_en, out_din
    );

    modport slave (
        output in_empty_ped, in_dout_ped,
        input  in_rd_en_ped,
        output in_empty_mask, in_dout_mask,
        input  in_rd_en_mask,
        output out_full,
        input  out_wr_en, out_din
    );
endinterface

// File: rtl/highlight_blend.sv
// rtl/highlight_blend.sv - mask-driven pixel highlighter with 2-entry output buffer
// Optional 50% blend for mode 10 is built only when HIGHLIGHT_BLEND_EN is defined.
module highlight_blend #(
    parameter int  CHAN_W       = 8,
    parameter int  NUM_CH       = 3,
    parameter int  MASK_THRESH  = 255,
    parameter int  FRAME_PIXELS = 388800,
    localparam int PIX_W        = CHAN_W * NUM_CH
) (
    input  logic               clock,
    input  logic               reset,
    highlight_blend_if.master  bus,
    input  logic [1:0]         mode,
    input  logic [PIX_W-1:0]   hl_color,
    output logic               frame_done
);
    localparam int               CNT_W       = $clog2(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [PIX_W-1:0] RESET_COLOR = PIX_W'({CHAN_W{1'b1}});

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t             state;
    logic [PIX_W-1:0] buf_head, buf_tail;
    logic [1:0]       act_mode;
    logic [PIX_W-1:0] act_color;
    logic [CNT_W-1:0] in_cnt, out_cnt;

    logic             pop, rd, first, hit;
    logic [1:0]       eff_mode;
    logic [PIX_W-1:0] eff_color, pix;
    logic             mask_unused;

    assign mask_unused = ^bus.in_dout_mask[PIX_W-1:CHAN_W];

    // A read is allowed into TWO only when the head leaves in the same cycle.
    assign pop   = (state != EMPTY) && !bus.out_full;
    assign rd    = !reset && !bus.in_empty_ped && !bus.in_empty_mask
                   && ((state != TWO) || pop);
    assign first = (in_cnt == '0);

    // The first pixel of a frame already uses the port values being latched.
    assign eff_mode  = first ? mode : act_mode;
    assign eff_color = first ? hl_color : act_color;
    assign hit       = bus.in_dout_mask[CHAN_W-1:0] >= CHAN_W'(MASK_THRESH);

`ifdef HIGHLIGHT_BLEND_EN
    logic [PIX_W-1:0] blend_pix;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_blend
        logic [CHAN_W:0] sum;
        assign sum = {1'b0, bus.in_dout_ped[c*CHAN_W +: CHAN_W]}
                   + {1'b0, eff_color[c*CHAN_W +: CHAN_W]};
        assign blend_pix[c*CHAN_W +: CHAN_W] = sum[CHAN_W:1];
    end
`endif

    always_comb begin
        pix = bus.in_dout_ped;
        if (hit) begin
            case (eff_mode)
                2'b00:   pix = bus.in_dout_ped;
`ifdef HIGHLIGHT_BLEND_EN
                2'b10:   pix = blend_pix;
`endif
                default: pix = eff_color;
            endcase
        end
    end

    assign bus.in_rd_en_ped  = rd;
    assign bus.in_rd_en_mask = rd;
    assign bus.out_wr_en     = !reset && pop;
    assign bus.out_din       = (!reset && pop) ? buf_head : '0;
    assign frame_done        = !reset && pop && (out_cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            buf_head  <= '0;
            buf_tail  <= '0;
            act_mode  <= 2'b01;
            act_color <= RESET_COLOR;
            in_cnt    <= '0;
            out_cnt   <= '0;
        end else begin
            if (rd) begin
                in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
                if (first) begin
                    act_mode  <= mode;
                    act_color <= hl_color;
                end
            end
            if (pop)
                out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;

            case (state)
                EMPTY: begin
                    if (rd) begin
                        buf_head <= pix;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (rd && pop) begin
                        buf_head <= pix;
                    end else if (rd) begin
                        buf_tail <= pix;
                        state    <= TWO;
                    end else if (pop) begin
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        buf_head <= buf_tail;
                        if (rd) buf_tail <= pix;
                        else    state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_highlight_blend.sv
// tb/tb_highlight_blend.sv - directed self-checking bench for highlight_blend
`timescale 1ns/1ps
module tb_highlight_blend;
    localparam int PIX_W = 24;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] mode = 2'b01;
    logic [PIX_W-1:0] hl_color = 24'h0000FF;
    logic frame_done;

    highlight_blend_if #(.PIX_W(PIX_W)) bus ();

    highlight_blend #(
        .CHAN_W(8), .NUM_CH(3), .MASK_THRESH(255), .FRAME_PIXELS(4)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .mode(mode), .hl_color(hl_color), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [PIX_W-1:0] ped_q[$];
    logic [PIX_W-1:0] mask_q[$];
    logic [PIX_W-1:0] got_q[$];
    int wr_cyc[$];
    int rd_cyc[$];
    int fd_cyc[$];
    int cyc = 0;
    int rd_cnt = 0;
    int split_cnt = 0;
    bit pop_pend = 1'b0;

    task automatic refresh();
        bus.in_empty_ped  = (ped_q.size() == 0);
        bus.in_dout_ped   = (ped_q.size() != 0) ? ped_q[0] : '0;
        bus.in_empty_mask = (mask_q.size() == 0);
        bus.in_dout_mask  = (mask_q.size() != 0) ? mask_q[0] : '0;
    endtask

    initial begin
        bus.out_full = 1'b0;
        refresh();
    end

    always @(negedge clock) begin
        cyc++;
        pop_pend = bus.in_rd_en_ped;
        if (bus.in_rd_en_ped) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
        end
        if (bus.in_rd_en_ped !== bus.in_rd_en_mask) split_cnt++;
        if (bus.out_wr_en) begin
            got_q.push_back(bus.out_din);
            wr_cyc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
    end

    always @(posedge clock) begin
        if (pop_pend) begin
            pop_pend = 1'b0;
            #1;
            if (ped_q.size() != 0)  void'(ped_q.pop_front());
            if (mask_q.size() != 0) void'(mask_q.pop_front());
            refresh();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_mon();
        got_q.delete(); wr_cyc.delete(); rd_cyc.delete(); fd_cyc.delete();
        rd_cnt = 0;
    endtask

    task automatic push(input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] m);
        ped_q.push_back(p);
        mask_q.push_back(m);
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.out_full = 1'b0;
        ped_q.delete(); mask_q.delete();
        refresh();
        step(2);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic wait_writes(input int n, input string name);
        int t = 0;
        while (got_q.size() < n && t < 200) begin
            step(1);
            t++;
        end
        step(2);
        checks++;
        if (got_q.size() !== n) begin
            errors++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1);
        push(24'h123456, 24'h0000FF);
        #1;
        checks++;
        if ({bus.in_rd_en_ped, bus.in_rd_en_mask, bus.out_wr_en, frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {bus.in_rd_en_ped, bus.in_rd_en_mask, bus.out_wr_en, frame_done});
        end
        checks++;
        if (bus.out_din !== 24'h0) begin
            errors++;
            $display("FAIL reset_din got=%h exp=000000", bus.out_din);
        end
        do_reset();
    endtask

    task automatic test_replace();
        logic [PIX_W-1:0] exp_v[8];
        do_reset();
        mode = 2'b01; hl_color = 24'h0000FF;
        push(24'h123456, 24'h0000FF); exp_v[0] = 24'h0000FF;
        push(24'h123456, 24'h0000FE); exp_v[1] = 24'h123456;
        push(24'hABCDEF, 24'hFFFF00); exp_v[2] = 24'hABCDEF;
        push(24'h00FF00, 24'h0000FF); exp_v[3] = 24'h0000FF;
        wait_writes(4, "replace");
        mode = 2'b11; hl_color = 24'h00AA00;
        push(24'h654321, 24'h0000FF); exp_v[4] = 24'h00AA00;
        push(24'h654321, 24'h000000); exp_v[5] = 24'h654321;
        push(24'h000001, 24'h0000FF); exp_v[6] = 24'h00AA00;
        push(24'h000002, 24'h0000FE); exp_v[7] = 24'h000002;
        wait_writes(8, "replace_m11");
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL replace_px%0d got=%h exp=%h", i, got_q[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_blend();
        logic [PIX_W-1:0] exp_v[4];
        do_reset();
        mode = 2'b10; hl_color = 24'hFF0000;
`ifdef HIGHLIGHT_BLEND_EN
        exp_v[0] = 24'h80017F;
        exp_v[2] = 24'hFF7F7F;
`else
        exp_v[0] = 24'hFF0000;
        exp_v[2] = 24'hFF0000;
`endif
        push(24'h0102FF, 24'h0000FF);
        push(24'h0102FF, 24'h000010); exp_v[1] = 24'h0102FF;
        push(24'hFFFFFF, 24'h0000FF);
        push(24'h000000, 24'h0000FE); exp_v[3] = 24'h000000;
        wait_writes(4, "blend");
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL blend_px%0d got=%h exp=%h", i, got_q[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 8; i++) push(24'h100000 + 24'(i), 24'h0000FF);
        wait_writes(8, "b2b");
        if (got_q.size() == 8) begin
            for (int i = 1; i < 8; i++) if (wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
            checks++;
            if (gaps !== 0) begin
                errors++;
                $display("FAIL b2b_gaps got=%0d exp=0", gaps);
            end
            checks++;
            if (wr_cyc[0] !== rd_cyc[0] + 1) begin
                errors++;
                $display("FAIL b2b_latency got=%0d exp=%0d", wr_cyc[0] - rd_cyc[0], 1);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== 24'h100000 + 24'(i)) begin
                    errors++;
                    $display("FAIL b2b_px%0d got=%h exp=%h", i, got_q[i], 24'h100000 + 24'(i));
                end
            end
            checks++;
            if (fd_cyc.size() !== 2) begin
                errors++;
                $display("FAIL b2b_frame_done_count got=%0d exp=2", fd_cyc.size());
            end else begin
                checks++;
                if (fd_cyc[0] !== wr_cyc[3] || fd_cyc[1] !== wr_cyc[7]) begin
                    errors++;
                    $display("FAIL b2b_frame_done_pos got=%0d,%0d exp=%0d,%0d",
                             fd_cyc[0], fd_cyc[1], wr_cyc[3], wr_cyc[7]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        mode = 2'b00;
        bus.out_full = 1'b1;
        for (int i = 0; i < 6; i++) push(24'h200000 + 24'(i), 24'h000000);
        step(5);
        checks++;
        if (rd_cnt !== 2 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_reads got=%0d/%0d exp=2/0", rd_cnt, got_q.size());
        end
        checks++;
        if ({bus.out_wr_en, bus.out_din} !== 25'h0) begin
            errors++;
            $display("FAIL stall_idle_out got=%b/%h exp=0/000000", bus.out_wr_en, bus.out_din);
        end
        bus.out_full = 1'b0;
        wait_writes(6, "stall");
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== 24'h200000 + 24'(i)) begin
                    errors++;
                    $display("FAIL stall_px%0d got=%h exp=%h", i, got_q[i], 24'h200000 + 24'(i));
                end
            end
        end
    endtask

    task automatic test_frame_latch();
        logic [PIX_W-1:0] e;
        do_reset();
        mode = 2'b01; hl_color = 24'h0000FF;
        push(24'h300000, 24'h0000FF);
        push(24'h300001, 24'h0000FF);
        wait_writes(2, "latch_a");
        mode = 2'b00; hl_color = 24'h777777;
        for (int i = 2; i < 8; i++) push(24'h300000 + 24'(i), 24'h0000FF);
        wait_writes(8, "latch_b");
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) begin
                e = (i < 4) ? 24'h0000FF : 24'h300000 + 24'(i);
                checks++;
                if (got_q[i] !== e) begin
                    errors++;
                    $display("FAIL latch_px%0d got=%h exp=%h", i, got_q[i], e);
                end
            end
        end
        checks++;
        if (fd_cyc.size() < 1 || wr_cyc.size() < 4 || fd_cyc[0] !== wr_cyc[3]) begin
            errors++;
            $display("FAIL latch_frame_done got=%0d pulses exp=pulse on 4th write", fd_cyc.size());
        end
    endtask

    task automatic test_one_empty();
        do_reset();
        mode = 2'b00;
        ped_q.push_back(24'h400000);
        refresh();
        step(3);
        checks++;
        if (rd_cnt !== 0 || ped_q.size() !== 1) begin
            errors++;
            $display("FAIL one_empty got=%0d reads/%0d left exp=0/1", rd_cnt, ped_q.size());
        end
        mask_q.push_back(24'h000000);
        refresh();
        wait_writes(1, "one_empty");
        checks++;
        if (got_q.size() != 0 && got_q[0] !== 24'h400000) begin
            errors++;
            $display("FAIL one_empty_px got=%h exp=400000", got_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b00;
        bus.out_full = 1'b1;
        push(24'h500000, 24'h000000);
        push(24'h500001, 24'h000000);
        push(24'h500002, 24'h0000FF);
        step(4);
        checks++;
        if (rd_cnt !== 2) begin
            errors++;
            $display("FAIL rstmid_reads got=%0d exp=2", rd_cnt);
        end
        reset = 1'b1;
        bus.out_full = 1'b0;
        mode = 2'b01; hl_color = 24'h111111;
        clear_mon();
        step(2);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL rstmid_writes_in_reset got=%0d exp=0", got_q.size());
        end
        reset = 1'b0;
        wait_writes(1, "rstmid");
        checks++;
        if (got_q.size() != 0 && got_q[0] !== 24'h111111) begin
            errors++;
            $display("FAIL rstmid_px got=%h exp=111111", got_q[0]);
        end
    endtask

    task automatic test_pairing();
        checks++;
        if (split_cnt !== 0) begin
            errors++;
            $display("FAIL rd_en_pairing got=%0d split cycles exp=0", split_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_replace();
        test_blend();
        test_back_to_back();
        test_full_stall();
        test_frame_latch();
        test_one_empty();
        test_reset_mid();
        test_pairing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
